flow_queue_n: RTL

// Parametrised N-entry decoupled FIFO. Successor to the single-entry flow queue that buffers

---
 rtl/flow_queue_n.sv | 113 +++++++++++
 1 files changed

// File: rtl/flow_queue_n.sv
// Parametrised N-entry decoupled FIFO with optional flow-through bypass, pipe-mode
// enqueue while full, occupancy count and synchronous flush.
module flow_queue_n #(
    parameter int WIDTH = 337,
    parameter int DEPTH = 2,
    parameter int FLOW  = 1,
    parameter int PIPE  = 0,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             io_flush,
    input  logic             io_enq_valid,
    output logic             io_enq_ready,
    input  logic [WIDTH-1:0] io_enq_bits,
    output logic             io_deq_valid,
    input  logic             io_deq_ready,
    output logic [WIDTH-1:0] io_deq_bits,
    output logic [CW-1:0]    io_count
);

    localparam int            PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST   = PW'(DEPTH - 1);
    localparam logic          FLOW_B = (FLOW != 0);
    localparam logic          PIPE_B = (PIPE != 0);

    logic [WIDTH-1:0] ram_q [DEPTH];
    logic [PW-1:0]    enq_ptr_q, enq_ptr_d;
    logic [PW-1:0]    deq_ptr_q, deq_ptr_d;
    logic             maybe_full_q, maybe_full_d;

    logic ptr_eq_s, empty_s, full_s;
    logic do_enq_s, do_deq_s, do_deq_mem_s, bypass_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == LAST) begin
            ptr_inc = {PW{1'b0}};
        end else begin
            ptr_inc = p + PW'(1);
        end
    endfunction

    // Handshake decode, bypass selection and occupancy from pointer state
    always_comb begin
        ptr_eq_s     = (enq_ptr_q == deq_ptr_q);
        empty_s      = ptr_eq_s & ~maybe_full_q;
        full_s       = ptr_eq_s & maybe_full_q;
        io_enq_ready = ~io_flush & (~full_s | (PIPE_B & io_deq_ready));
        io_deq_valid = ~io_flush & (~empty_s | (FLOW_B & io_enq_valid));
        io_deq_bits  = (FLOW_B & empty_s) ? io_enq_bits : ram_q[deq_ptr_q];
        do_deq_s     = io_deq_valid & io_deq_ready;
        // A beat that passes straight through never touches storage.
        bypass_s     = FLOW_B & empty_s & do_deq_s;
        do_enq_s     = io_enq_valid & io_enq_ready & ~bypass_s;
        do_deq_mem_s = do_deq_s & ~bypass_s;
        if (full_s) begin
            io_count = CW'(DEPTH);
        end else if (enq_ptr_q >= deq_ptr_q) begin
            io_count = CW'(enq_ptr_q - deq_ptr_q);
        end else begin
            io_count = CW'(DEPTH) - CW'(deq_ptr_q) + CW'(enq_ptr_q);
        end
    end

    // Next-state pointers and full/empty disambiguation
    always_comb begin
        enq_ptr_d    = enq_ptr_q;
        deq_ptr_d    = deq_ptr_q;
        maybe_full_d = maybe_full_q;
        if (io_flush) begin
            enq_ptr_d    = {PW{1'b0}};
            deq_ptr_d    = {PW{1'b0}};
            maybe_full_d = 1'b0;
        end else begin
            if (do_enq_s) begin
                enq_ptr_d = ptr_inc(enq_ptr_q);
            end else begin
                enq_ptr_d = enq_ptr_q;
            end
            if (do_deq_mem_s) begin
                deq_ptr_d = ptr_inc(deq_ptr_q);
            end else begin
                deq_ptr_d = deq_ptr_q;
            end
            if (do_enq_s != do_deq_mem_s) begin
                maybe_full_d = do_enq_s;
            end else begin
                maybe_full_d = maybe_full_q;
            end
        end
    end

    // Pointer and flag registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            enq_ptr_q    <= {PW{1'b0}};
            deq_ptr_q    <= {PW{1'b0}};
            maybe_full_q <= 1'b0;
        end else begin
            enq_ptr_q    <= enq_ptr_d;
            deq_ptr_q    <= deq_ptr_d;
            maybe_full_q <= maybe_full_d;
        end
    end

    // Payload storage, intentionally left unreset
    always_ff @(posedge clock) begin
        if (do_enq_s) begin
            ram_q[enq_ptr_q] <= io_enq_bits;
        end
    end

endmodule
